xalu_nibble_seq: RTL and testbench
==================================

Name: xalu_nibble_seq

Overview:
- Sequencer that runs multi-nibble (4*NIBBLES-bit) operations through the external combinational 4-bit ALU slice, one nibble per cycle.
- Latches wide operands, drives the slice's A/B/function/COM/carry-in pins, and captures the slice's 4-bit result and carry/equality outputs nibble by nibble.
- Chains the slice's carries between nibbles.
- Presents the assembled wide result with carry, zero, neg-zero and equality flags.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation. Operand width W = 4*NIBBLES. Legal range 2..8.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only in IDLE
- op  in  3  function code, same encoding as slice: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL
- com  in  1  1's-complement output mode, forwarded to the slice
- cin  in  1  ADD carry-in for least significant nibble
- sin  in  1  shift-in bit: LSB for SHL, MSB for SHR
- a_in  in  W  operand A, sampled on accepted start
- b_in  in  W  operand B, sampled on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when result and flags are valid
- result  out  W  assembled result, held until next accepted start
- carry_out  out  1  final carry (see Behaviour)
- zero  out  1  result == 0
- neg_zero  out  1  result == all ones
- equ  out  1  A == B over all W bits
- alu_a  out  4  current A nibble to slice
- alu_b  out  4  current B nibble to slice
- alu_f  out  3  function code to slice
- alu_com  out  1  COM to slice
- alu_ci_right  out  1  right carry-in to slice
- alu_ci_left  out  1  left carry-in to slice
- alu_d  in  4  slice result nibble
- alu_co_left  in  1  slice left carry-out
- alu_co_right  in  1  slice right carry-out
- alu_equ  in  1  slice nibble-equal output

Behaviour:
- Reset (async, rst_n low): state IDLE. busy, done, result, carry_out, zero, neg_zero, equ, all alu_* outputs and internal operand/index/carry registers are 0. Reset mid-RUN aborts the operation immediately; no done pulse is issued.
- States:
  - IDLE: start=1 latches a_in, b_in, op, com, cin, sin. Index is set to 0, or NIBBLES-1 for SHR. Equality accumulator is set to 1; carry register is seeded (cin for ADD, sin for SHL/SHR, 0 otherwise). Go to RUN.
  - RUN: busy=1. Each cycle the slice is driven combinationally from registers: alu_a/alu_b = latched nibble[index], alu_f = op, alu_com = com.
    - alu_ci_right = carry register for ADD/SHL, else 0.
    - alu_ci_left = carry register for SHR, else 0.
    - At the clock edge: alu_d is written to result nibble[index]; equality accumulator ANDs alu_equ; carry register takes alu_co_left (ADD/SHL) or alu_co_right (SHR).
    - After the last nibble (index NIBBLES-1, or 0 for SHR), go to DONE. Otherwise index steps +1 (or -1 for SHR).
  - DONE: done=1 for exactly one cycle. carry_out = final carry register for ADD/SHL/SHR, 0 for ops 1-5. zero/neg_zero are computed from the full result; equ = equality accumulator. Return to IDLE.
- Latency: accepted start at edge N gives busy high in cycles N+1..N+NIBBLES and done high in cycle N+NIBBLES+1. Back-to-back start in the DONE-following IDLE cycle is legal.
- start while busy or done is ignored; latched operands are unchanged.
- result and flags change only at nibble capture and are stable from the done pulse until the next accepted start. result is partially updated during RUN; consumers must use done.
- com is applied per nibble by the slice. The sequencer performs no end-around carry.
- alu_* outputs are 0 in IDLE and DONE.

Test Plan:
- NIBBLES=4 with a behavioural slice model attached. ADD a=0x1234 b=0x0FCD cin=0 → result 0x2201, carry_out 0, zero 0. done exactly 5 cycles after start edge; busy high 4 cycles.
- ADD a=0xFFFF b=0x0001 cin=0 → result 0x0000, carry_out 1, zero 1, neg_zero 0, equ 0.
- SHR a=0x8001 sin=1 → result 0xC000, carry_out 1. alu_a sequence observed as 0x8, 0x0, 0x0, 0x1.
- SHL a=0x8001 sin=0 → result 0x0002, carry_out 1. XOR com=1 a=b=0x5A5A → result 0xFFFF, neg_zero 1, zero 0, equ 1, carry_out 0.
- start pulsed again during RUN with different operands → ignored; original result delivered. rst_n low in 2nd RUN cycle → busy/result/alu_* 0 immediately, no done; a fresh start after release completes normally.

Source files
------------

// File: rtl/xalu_nibble_seq_if.sv
// Request/response bundle between a client and the multi-nibble ALU sequencer.
// The client drives the operation and operands; the sequencer returns status, result and flags.
interface xalu_nibble_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [2:0]   op;
  logic         com;
  logic         cin;
  logic         sin;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;
  logic         neg_zero;
  logic         equ;

  modport master (
    output start, op, com, cin, sin, a_in, b_in,
    input  busy, done, result, carry_out, zero, neg_zero, equ
  );

  modport slave (
    input  start, op, com, cin, sin, a_in, b_in,
    output busy, done, result, carry_out, zero, neg_zero, equ
  );
endinterface

// File: rtl/xalu_nibble_seq.sv
// Runs a 4*NIBBLES-bit operation through an external combinational 4-bit ALU slice,
// one nibble per cycle, chaining carries and assembling the wide result and flags.
module xalu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  xalu_nibble_seq_if.slave    bus,
  output logic [3:0]          alu_a,
  output logic [3:0]          alu_b,
  output logic [2:0]          alu_f,
  output logic                alu_com,
  output logic                alu_ci_right,
  output logic                alu_ci_left,
  input  logic [3:0]          alu_d,
  input  logic                alu_co_left,
  input  logic                alu_co_right,
  input  logic                alu_equ
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [2:0]    op_r;
  logic          com_r;
  logic [IW-1:0] idx_r;
  logic          carry_r;
  logic          eq_acc_r;
  logic [W-1:0]  result_r;
  logic          carry_out_r;
  logic          zero_r;
  logic          neg_zero_r;
  logic          equ_r;

  logic          is_shr_s;
  logic          carry_op_s;
  logic          last_s;
  logic          seed_s;
  logic          carry_nxt_s;
  logic [W-1:0]  result_nxt_s;

  assign is_shr_s    = (op_r == OP_SHR);
  assign carry_op_s  = (op_r == OP_ADD) || (op_r == OP_SHL) || (op_r == OP_SHR);
  assign last_s      = is_shr_s ? (idx_r == {IW{1'b0}}) : (idx_r == IDX_LAST);
  // Shift-right ripples from the top nibble down, so its chain uses the right-hand carry-out.
  assign carry_nxt_s = is_shr_s ? alu_co_right : alu_co_left;

  // Carry seed for the first nibble, chosen from the incoming request.
  always_comb begin
    seed_s = 1'b0;
    case (bus.op)
      OP_ADD:         seed_s = bus.cin;
      OP_SHL, OP_SHR: seed_s = bus.sin;
      default:        seed_s = 1'b0;
    endcase
  end

  // Result with the slice output merged into the nibble being processed.
  always_comb begin
    result_nxt_s = result_r;
    result_nxt_s[{idx_r, 2'b00} +: 4] = alu_d;
  end

  // Slice pin drive: active only while running, quiet otherwise.
  always_comb begin
    alu_a        = 4'd0;
    alu_b        = 4'd0;
    alu_f        = 3'd0;
    alu_com      = 1'b0;
    alu_ci_right = 1'b0;
    alu_ci_left  = 1'b0;
    if (state_r == ST_RUN) begin
      alu_a        = a_r[{idx_r, 2'b00} +: 4];
      alu_b        = b_r[{idx_r, 2'b00} +: 4];
      alu_f        = op_r;
      alu_com      = com_r;
      alu_ci_right = ((op_r == OP_ADD) || (op_r == OP_SHL)) ? carry_r : 1'b0;
      alu_ci_left  = is_shr_s ? carry_r : 1'b0;
    end else begin
      alu_a        = 4'd0;
      alu_b        = 4'd0;
      alu_f        = 3'd0;
      alu_com      = 1'b0;
      alu_ci_right = 1'b0;
      alu_ci_left  = 1'b0;
    end
  end

  // Sequencer state, operand latches and per-nibble capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      op_r        <= 3'd0;
      com_r       <= 1'b0;
      idx_r       <= {IW{1'b0}};
      carry_r     <= 1'b0;
      eq_acc_r    <= 1'b0;
      result_r    <= {W{1'b0}};
      carry_out_r <= 1'b0;
      zero_r      <= 1'b0;
      neg_zero_r  <= 1'b0;
      equ_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            a_r      <= bus.a_in;
            b_r      <= bus.b_in;
            op_r     <= bus.op;
            com_r    <= bus.com;
            idx_r    <= (bus.op == OP_SHR) ? IDX_LAST : {IW{1'b0}};
            carry_r  <= seed_s;
            eq_acc_r <= 1'b1;
            state_r  <= ST_RUN;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          result_r <= result_nxt_s;
          eq_acc_r <= eq_acc_r & alu_equ;
          carry_r  <= carry_nxt_s;
          if (last_s) begin
            // Flags are taken from the fully assembled result at the final capture.
            carry_out_r <= carry_op_s ? carry_nxt_s : 1'b0;
            zero_r      <= (result_nxt_s == {W{1'b0}});
            neg_zero_r  <= (result_nxt_s == {W{1'b1}});
            equ_r       <= eq_acc_r & alu_equ;
            state_r     <= ST_DONE;
          end else begin
            idx_r       <= is_shr_s ? (idx_r - IDX_ONE) : (idx_r + IDX_ONE);
            state_r     <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (state_r == ST_RUN);
  assign bus.done      = (state_r == ST_DONE);
  assign bus.result    = result_r;
  assign bus.carry_out = carry_out_r;
  assign bus.zero      = zero_r;
  assign bus.neg_zero  = neg_zero_r;
  assign bus.equ       = equ_r;
endmodule

// File: tb/tb_xalu_nibble_seq.sv
// Scoreboard bench for xalu_nibble_seq with a behavioural 4-bit slice attached.
// Expected responses are queued at issue time and checked by a monitor on each done pulse.
module tb_xalu_nibble_seq;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_PB  = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  typedef struct packed {
    logic [15:0] result;
    logic        carry;
    logic        zero;
    logic        neg_zero;
    logic        equ;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] alu_a, alu_b, alu_d;
  logic [2:0] alu_f;
  logic       alu_com, alu_ci_right, alu_ci_left;
  logic       alu_co_left, alu_co_right, alu_equ;
  logic [4:0] sum_s;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [3:0] alua_q[$];
  logic [3:0] shr_seq [4];

  xalu_nibble_seq_if #(.NIBBLES(NIB)) bus();

  xalu_nibble_seq #(.NIBBLES(NIB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_f        (alu_f),
    .alu_com      (alu_com),
    .alu_ci_right (alu_ci_right),
    .alu_ci_left  (alu_ci_left),
    .alu_d        (alu_d),
    .alu_co_left  (alu_co_left),
    .alu_co_right (alu_co_right),
    .alu_equ      (alu_equ)
  );

  always #5 clk = ~clk;

  assign sum_s = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_ci_right};

  // Behavioural 4-bit slice: COM complements the data output only.
  always_comb begin
    alu_d        = 4'd0;
    alu_co_left  = 1'b0;
    alu_co_right = 1'b0;
    case (alu_f)
      3'd0: begin alu_d = sum_s[3:0]; alu_co_left = sum_s[4]; end
      3'd1: alu_d = alu_a & alu_b;
      3'd2: alu_d = alu_a | alu_b;
      3'd3: alu_d = alu_a ^ alu_b;
      3'd4: alu_d = alu_a;
      3'd5: alu_d = alu_b;
      3'd6: begin alu_d = {alu_ci_left, alu_a[3:1]}; alu_co_right = alu_a[0]; end
      default: begin alu_d = {alu_a[2:0], alu_ci_right}; alu_co_left = alu_a[3]; end
    endcase
    if (alu_com) alu_d = ~alu_d;
    alu_equ = (alu_a == alu_b);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      check("done_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("result",    {16'd0, bus.result}, {16'd0, mon_e.result});
        check("carry_out", {31'd0, bus.carry_out}, {31'd0, mon_e.carry});
        check("zero",      {31'd0, bus.zero}, {31'd0, mon_e.zero});
        check("neg_zero",  {31'd0, bus.neg_zero}, {31'd0, mon_e.neg_zero});
        check("equ",       {31'd0, bus.equ}, {31'd0, mon_e.equ});
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic com, input logic cin, input logic sin,
                       input logic [15:0] a, input logic [15:0] b, input exp_t e,
                       input bit poke, input bit rec);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.com = com; bus.cin = cin; bus.sin = sin;
    bus.a_in = a; bus.b_in = b;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0; bus.op = op ^ 3'd1; bus.com = ~com; bus.cin = ~cin; bus.sin = ~sin;
    bus.a_in = ~a; bus.b_in = ~b;
    cyc = 1;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      if (bus.busy === 1'b1) begin
        busy_cnt++;
        if (rec) alua_q.push_back(alu_a);
      end
      if (poke && cyc == 2) begin
        bus.start = 1'b1; bus.op = 3'd4; bus.a_in = 16'h0000; bus.b_in = 16'h1234;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check("done_latency", cyc, 32'd5);
    check("busy_cycles", busy_cnt, 32'd4);
    check("busy_at_done", {31'd0, bus.busy}, 32'd0);
    check("alu_a_at_done", {28'd0, alu_a}, 32'd0);
  endtask

  initial begin
    shr_seq = '{4'h8, 4'h0, 4'h0, 4'h1};
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 3'd0; bus.com = 1'b0; bus.cin = 1'b0; bus.sin = 1'b0;
    bus.a_in = 16'h0000; bus.b_in = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset_status", {22'd0, bus.busy, bus.done, bus.carry_out, bus.zero, bus.neg_zero,
                           bus.equ, alu_com, alu_ci_right, alu_ci_left, alu_f}, 32'd0);
    check("reset_result", {16'd0, bus.result}, 32'd0);
    check("reset_alu_ab", {24'd0, alu_a, alu_b}, 32'd0);
    rst_n = 1'b1;

    issue(OP_ADD, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0FCD, exp_t'{16'h2201, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0, 1'b0);
    issue(OP_ADD, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, exp_t'{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}, 1'b0, 1'b0);
    alua_q.delete();
    issue(OP_SHR, 1'b0, 1'b0, 1'b1, 16'h8001, 16'h0000, exp_t'{16'hC000, 1'b1, 1'b0, 1'b0, 1'b0}, 1'b0, 1'b1);
    check("shr_alu_a_count", alua_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < alua_q.size()) check("shr_alu_a_seq", {28'd0, alua_q[i]}, {28'd0, shr_seq[i]});
    end
    issue(OP_SHL, 1'b0, 1'b0, 1'b0, 16'h8001, 16'h0000, exp_t'{16'h0002, 1'b1, 1'b0, 1'b0, 1'b0}, 1'b0, 1'b0);
    issue(OP_XOR, 1'b1, 1'b0, 1'b0, 16'h5A5A, 16'h5A5A, exp_t'{16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1}, 1'b0, 1'b0);
    issue(OP_ADD, 1'b0, 1'b1, 1'b0, 16'h1111, 16'h1111, exp_t'{16'h2223, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b0, 1'b0);
    issue(OP_OR,  1'b1, 1'b0, 1'b0, 16'h0F0F, 16'h00F0, exp_t'{16'hF000, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0, 1'b0);
    issue(OP_AND, 1'b0, 1'b0, 1'b0, 16'hF0F0, 16'hFF00, exp_t'{16'hF000, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b0);
    issue(OP_PB,  1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF, exp_t'{16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b0, 1'b0);
    issue(OP_ADD, 1'b0, 1'b1, 1'b0, 16'h7FFF, 16'h0000, exp_t'{16'h8000, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0, 1'b0);

    // Abort an operation with reset in its second RUN cycle; no done may follow.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_ADD; bus.com = 1'b0; bus.cin = 1'b0;
    bus.a_in = 16'h1111; bus.b_in = 16'h2222;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_result", {16'd0, bus.result}, 32'd0);
    check("abort_alu", {21'd0, alu_a, alu_b, alu_f}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, bus.done}, 32'd0);
    end
    rst_n = 1'b1;
    issue(OP_ADD, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0002, exp_t'{16'h0003, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
